// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory responder.
//   dmem_size_e  : access size encoding driven by the core's memctr/memsel path
//   dmem_state_e : responder FSM states
//   dmem_req_t   : captured request fields
//   is_misaligned: alignment rule for a given size and byte lane
package dmem_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;
    localparam int XLEN      = NUM_LANES * LANE_W;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } dmem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } dmem_state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        dmem_size_e      size;
        logic            is_unsigned;
    } dmem_req_t;

    // Halves must sit on an even byte, words on a word boundary.
    function automatic logic is_misaligned(input dmem_size_e size, input logic [1:0] lane);
        case (size)
            SZ_HALF: is_misaligned = lane[0];
            SZ_WORD: is_misaligned = (lane != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: combinational lane steering for one 32-bit RAM word.
//   size, lane, is_unsigned : captured request attributes
//   wdata                   : right-justified store data
//   raw_word                : current RAM word at the target index
//   be                      : per-byte write enables
//   wdata_rep               : store data replicated onto every byte lane
//   misalign                : alignment violation for this size/lane
//   size_bad                : illegal size encoding
//   rdata_ext               : load data shifted down and sign/zero extended
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  dmem_size_e                          size,
    input  logic [1:0]                          lane,
    input  logic                                is_unsigned,
    input  logic [XLEN-1:0]                     wdata,
    input  logic [XLEN-1:0]                     raw_word,
    output logic [NUM_LANES-1:0]                be,
    output logic [NUM_LANES-1:0][LANE_W-1:0]    wdata_rep,
    output logic                                misalign,
    output logic                                size_bad,
    output logic [XLEN-1:0]                     rdata_ext
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        be = '0;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = 4'b0011 << lane;
            SZ_WORD: be = 4'b1111;
            default: be = '0;
        endcase
    end

    // Replicate so that whichever lanes are enabled see the right slice:
    // bytes go everywhere, halves repeat in both halves of the word.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_rep
        always_comb begin
            case (size)
                SZ_BYTE: wdata_rep[i] = wdata[LANE_W-1:0];
                SZ_HALF: wdata_rep[i] = wdata[LANE_W*(i%2) +: LANE_W];
                default: wdata_rep[i] = wdata[LANE_W*i +: LANE_W];
            endcase
        end
    end

    assign misalign = is_misaligned(size, lane);
    assign size_bad = (size == SZ_BAD);

    assign shifted = raw_word >> {lane, 3'b000};

    always_comb begin
        rdata_ext = raw_word;
        case (size)
            SZ_BYTE: rdata_ext = is_unsigned ? {24'b0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: rdata_ext = is_unsigned ? {16'b0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: rdata_ext = raw_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory target for the RV32I load/store port.
//   clk, rst       : clock, synchronous active-high reset
//   req_*          : request channel (valid/ready), store data right-justified
//   resp_*         : response channel (valid/ready), extended load data + error flag
// Flow: IDLE (accept, then one capture cycle) -> WAIT (WAIT_CYCLES) -> ACCESS -> RESP.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_e state_q, state_d;
    logic        pend_q, pend_d;   // request captured, not yet left IDLE
    logic [3:0]  wcnt_q, wcnt_d;
    dmem_req_t   req_q;

    logic        ready_d, valid_d, err_d;
    logic [31:0] rdata_d;

    logic        accept;
    logic [31:0] off;
    logic        out_of_range;
    logic [AW-1:0] word_idx;
    logic [31:0] raw_word;
    logic        acc_err;
    logic        do_write;

    logic [NUM_LANES-1:0]             fmt_be;
    logic [NUM_LANES-1:0][LANE_W-1:0] fmt_wdata;
    logic                             fmt_misalign, fmt_size_bad;
    logic [31:0]                      fmt_rdata;

    logic [NUM_LANES-1:0][LANE_W-1:0] mem [DEPTH_WORDS];

    assign accept = req_valid && req_ready;

    // Range check on the captured address; the 33-bit compare keeps the
    // span exact even when DEPTH_WORDS*4 reaches 2^32.
    assign off          = req_q.addr - BASE_ADDR;
    assign out_of_range = (req_q.addr < BASE_ADDR) || ({1'b0, off} >= SPAN);
    assign word_idx     = off[AW+1:2];
    assign raw_word     = mem[word_idx];

    dmem_lane_fmt u_fmt (
        .size        (req_q.size),
        .lane        (req_q.addr[1:0]),
        .is_unsigned (req_q.is_unsigned),
        .wdata       (req_q.wdata),
        .raw_word    (raw_word),
        .be          (fmt_be),
        .wdata_rep   (fmt_wdata),
        .misalign    (fmt_misalign),
        .size_bad    (fmt_size_bad),
        .rdata_ext   (fmt_rdata)
    );

    assign acc_err  = fmt_misalign || fmt_size_bad || out_of_range;
    // Reset in the ACCESS cycle aborts the store along with the transaction.
    assign do_write = !rst && (state_q == ST_ACCESS) && req_q.we && !acc_err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pend_d  = 1'b0;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                    wcnt_d  = '0;
                end else if (accept) begin
                    pend_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == WAIT_LAST) state_d = ST_ACCESS;
                else                     wcnt_d  = wcnt_q + 4'd1;
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   if (resp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        ready_d = (state_d == ST_IDLE) && !pend_d;
        valid_d = (state_d == ST_RESP);
        err_d   = 1'b0;
        rdata_d = '0;
        if (state_q == ST_ACCESS) begin
            err_d   = acc_err;
            rdata_d = (!req_q.we && !acc_err) ? fmt_rdata : 32'h0;
        end else if (state_d == ST_RESP) begin
            err_d   = resp_err;
            rdata_d = resp_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            req_ready  <= ready_d;
            resp_valid <= valid_d;
            resp_rdata <= rdata_d;
            resp_err   <= err_d;
        end
    end

    // Request capture: datapath only, qualified by the handshake.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_q.we          <= req_we;
            req_q.addr        <= req_addr;
            req_q.wdata       <= req_wdata;
            req_q.size        <= dmem_size_e'(req_size);
            req_q.is_unsigned <= req_unsigned;
        end
    end

    // RAM: not reset, byte-lane writes.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (fmt_be[i]) mem[word_idx][i] <= fmt_wdata[i];
            end
        end
    end

endmodule
